// File: rtl/sbqm_pkg.sv
// sbqm_pkg -- shared types and helpers for the bank-queue manager.
//   div_state_e  : wait-time divider sequencing (IDLE, DIV, DONE)
//   SVC_TIME_DEF : default service time per person, in minutes
//   pcWidth / tcWidth / wtWidth : width helpers for person count,
//                                 teller count and wait time
package sbqm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } div_state_e;

  localparam int SVC_TIME_DEF = 3;

  function automatic int pcWidth(input int maxPersons);
    return $clog2(maxPersons + 1);
  endfunction

  function automatic int tcWidth(input int maxTellers);
    return $clog2(maxTellers + 1);
  endfunction

  // Wide enough for SVC_TIME*(pCount+tEff-1) at its largest.
  function automatic int wtWidth(input int svcTime, input int maxPersons, input int maxTellers);
    return $clog2(svcTime * (maxPersons + maxTellers) + 1);
  endfunction

endpackage

// File: rtl/sbqm_if.sv
// sbqm_if -- sensor/status bundle of the bank-queue manager.
//   a, b       : back (entry) and front (exit) photocell levels
//   tCount     : number of active tellers
//   pCount     : persons in queue
//   wTime      : estimated wait in minutes, wValid marks it current
//   emptyFlag, fullFlag, errPulse : queue status
// master = sensor/display side, slave = queue manager.
interface sbqm_if #(
  parameter int PC_W = 3,
  parameter int TC_W = 2,
  parameter int WT_W = 5
);
  logic            a;
  logic            b;
  logic [TC_W-1:0] tCount;
  logic [PC_W-1:0] pCount;
  logic [WT_W-1:0] wTime;
  logic            wValid;
  logic            emptyFlag;
  logic            fullFlag;
  logic            errPulse;

  modport master (
    output a, b, tCount,
    input  pCount, wTime, wValid, emptyFlag, fullFlag, errPulse
  );

  modport slave (
    input  a, b, tCount,
    output pCount, wTime, wValid, emptyFlag, fullFlag, errPulse
  );
endinterface

// File: rtl/sbqm_divider.sv
// sbqm_divider -- unsigned sequential restoring divider, one quotient bit
// per cycle, DW cycles per division.
//   clk, reset : clock, synchronous active-high reset
//   start      : latch dividend/divisor and begin (also aborts a running divide)
//   dividend   : DW-bit numerator
//   divisor    : VW-bit denominator, must be non-zero
//   quotient   : result, valid the cycle after done
//   done       : high while the final quotient bit is being produced
module sbqm_divider #(
  parameter int DW = 5,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] r_quo;
  logic [VW-1:0] r_rem;
  logic [VW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [VW:0]   w_trial;
  logic          w_fits;

  // The partial remainder is always below the divisor, so it fits VW bits
  // and only the shifted trial value needs the extra bit.
  assign w_trial = {r_rem, r_quo[DW-1]};
  assign w_fits  = (w_trial >= {1'b0, r_div});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_div <= divisor;
      r_cnt <= CW'(DW);
    end else if (r_cnt != '0) begin
      r_rem <= w_fits ? VW'(w_trial - {1'b0, r_div}) : w_trial[VW-1:0];
      r_quo <= {r_quo[DW-2:0], w_fits};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign quotient = r_quo;
  assign done     = (r_cnt == CW'(1));

endmodule

// File: rtl/sbqm_multi_teller.sv
// sbqm_multi_teller -- parametrised bank-queue manager.
// Counts persons from two photocells (a = entry, b = exit), drives the
// occupancy count, empty/full flags and an estimated wait time
// floor(SVC_TIME*(pCount+tEff-1)/tEff) computed by a sequential divider.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : sbqm_if slave (a, b, tCount in; pCount, wTime, wValid,
//           emptyFlag, fullFlag, errPulse out)
// Optional macro SBQM_DEBOUNCE_EN: each synchronised sensor must hold a
// new level for DEB_CYCLES cycles before its edge is counted.
module sbqm_multi_teller
  import sbqm_pkg::*;
#(
  parameter int MAX_PERSONS = 7,
  parameter int MAX_TELLERS = 3,
  parameter int SVC_TIME    = SVC_TIME_DEF,
  parameter int DEB_CYCLES  = 4
) (
  input logic   clk,
  input logic   reset,
  sbqm_if.slave bus
);

  localparam int PC_W = pcWidth(MAX_PERSONS);
  localparam int TC_W = tcWidth(MAX_TELLERS);
  localparam int WT_W = wtWidth(SVC_TIME, MAX_PERSONS, MAX_TELLERS);

  // Index 0 = entry sensor a, index 1 = exit sensor b.
  logic [1:0]      r_meta;
  logic [1:0]      r_sync;
  logic [1:0]      r_prev;
  logic [1:0]      w_level;
  logic [1:0]      w_rise;
  logic [PC_W-1:0] r_pCount;
  logic [PC_W-1:0] w_countNext;
  logic            w_err;
  logic            r_empty;
  logic            r_full;
  logic            r_err;
  logic [TC_W-1:0] w_tEff;
  logic [WT_W-1:0] w_dividend;
  logic [WT_W-1:0] w_quotient;
  logic            w_divDone;
  logic            w_change;
  logic            w_start;
  logic            w_loadZero;
  logic            w_loadRes;
  div_state_e      r_state;
  div_state_e      w_stateNext;
  logic [PC_W-1:0] r_latP;
  logic [TC_W-1:0] r_latT;
  logic [WT_W-1:0] r_wTime;
  logic            r_wValid;

  // Two-flop synchronisers, then an edge detector on the settled level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= {bus.b, bus.a};
      r_sync <= r_meta;
      r_prev <= w_level;
    end
  end

`ifdef SBQM_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEB_CYCLES + 1);

  logic [DB_W-1:0] r_debCnt [2];
  logic [1:0]      r_debLevel;

  // A new level is accepted only after it has been seen DEB_CYCLES times in
  // a row; any return to the old level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_debCnt[0] <= '0;
      r_debCnt[1] <= '0;
      r_debLevel  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_debLevel[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == DB_W'(DEB_CYCLES - 1)) begin
          r_debLevel[i] <= r_sync[i];
          r_debCnt[i]   <= '0;
        end else begin
          r_debCnt[i] <= r_debCnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_level = r_debLevel;
`else
  // DEB_CYCLES has no effect without debounce; the guard only keeps it referenced.
  if (DEB_CYCLES >= 0) begin : g_direct
    assign w_level = r_sync;
  end
`endif

  assign w_rise = w_level & ~r_prev;

  // Simultaneous entry and exit cancel out, even at full or empty.
  always_comb begin
    w_countNext = r_pCount;
    w_err       = 1'b0;
    if (w_rise[0] && !w_rise[1]) begin
      if (r_pCount == PC_W'(MAX_PERSONS)) w_err = 1'b1;
      else                                w_countNext = r_pCount + PC_W'(1);
    end else if (w_rise[1] && !w_rise[0]) begin
      if (r_pCount == '0) w_err = 1'b1;
      else                w_countNext = r_pCount - PC_W'(1);
    end
  end

  // Flags are derived from the next count so they move with pCount.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pCount <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_pCount <= w_countNext;
      r_empty  <= (w_countNext == '0);
      r_full   <= (w_countNext == PC_W'(MAX_PERSONS));
      r_err    <= w_err;
    end
  end

  // Zero tellers still means one window serving; extra tellers saturate.
  always_comb begin
    w_tEff = bus.tCount;
    if (bus.tCount == '0)                                   w_tEff = TC_W'(1);
    else if ({1'b0, bus.tCount} > (TC_W + 1)'(MAX_TELLERS)) w_tEff = TC_W'(MAX_TELLERS);
  end

  assign w_dividend = WT_W'(SVC_TIME * (int'(r_pCount) + int'(w_tEff) - 1));
  assign w_change   = (r_pCount != r_latP) || (w_tEff != r_latT);

  sbqm_divider #(
    .DW(WT_W),
    .VW(TC_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .dividend (w_dividend),
    .divisor  (w_tEff),
    .quotient (w_quotient),
    .done     (w_divDone)
  );

  // Any operand change, in any state, restarts from fresh operands; an
  // empty queue skips the divider entirely since its answer is always 0.
  always_comb begin
    w_stateNext = r_state;
    w_start     = 1'b0;
    w_loadZero  = 1'b0;
    w_loadRes   = 1'b0;
    if (w_change) begin
      if (r_pCount == '0) begin
        w_loadZero  = 1'b1;
        w_stateNext = IDLE;
      end else begin
        w_start     = 1'b1;
        w_stateNext = DIV;
      end
    end else begin
      case (r_state)
        DIV:     if (w_divDone) w_stateNext = DONE;
        DONE: begin
          w_loadRes   = 1'b1;
          w_stateNext = IDLE;
        end
        default: ;
      endcase
    end
  end

  // wTime keeps its previous value until a new result is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_latP   <= '0;
      r_latT   <= TC_W'(1);
      r_wTime  <= '0;
      r_wValid <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      if (w_start || w_loadZero) begin
        r_latP <= r_pCount;
        r_latT <= w_tEff;
      end
      if (w_start) r_wValid <= 1'b0;
      if (w_loadZero) begin
        r_wTime  <= '0;
        r_wValid <= 1'b1;
      end
      if (w_loadRes) begin
        r_wTime  <= w_quotient;
        r_wValid <= 1'b1;
      end
    end
  end

  assign bus.pCount    = r_pCount;
  assign bus.emptyFlag = r_empty;
  assign bus.fullFlag  = r_full;
  assign bus.errPulse  = r_err;
  assign bus.wTime     = r_wTime;
  assign bus.wValid    = r_wValid;

endmodule

// File: tb/tb_sbqm_multi_teller.sv
// tb_sbqm_multi_teller -- self-checking bench for sbqm_multi_teller.
// Table of {sensor pulses, tCount, expected outputs} records applied in
// sequence, plus hand-written sequences for latency, abort, full/empty
// rejection, simultaneous sensors and reset during a division.
// Honours SBQM_DEBOUNCE_EN when the design is built with it.
module tb_sbqm_multi_teller;
  import sbqm_pkg::*;

  localparam int MAX_PERSONS = 7;
  localparam int MAX_TELLERS = 3;
  localparam int SVC_TIME    = 3;
  localparam int DEB_CYCLES  = 4;
  localparam int PC_W = pcWidth(MAX_PERSONS);
  localparam int TC_W = tcWidth(MAX_TELLERS);
  localparam int WT_W = wtWidth(SVC_TIME, MAX_PERSONS, MAX_TELLERS);
`ifdef SBQM_DEBOUNCE_EN
  localparam int EXP_LAT = 3 + DEB_CYCLES;
`else
  localparam int EXP_LAT = 3;
`endif

  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatch;
  int   errSeen;

  sbqm_if #(.PC_W(PC_W), .TC_W(TC_W), .WT_W(WT_W)) bus ();

  sbqm_multi_teller #(
    .MAX_PERSONS (MAX_PERSONS),
    .MAX_TELLERS (MAX_TELLERS),
    .SVC_TIME    (SVC_TIME),
    .DEB_CYCLES  (DEB_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with errPulse high is counted, so a stretched pulse shows up.
  always @(negedge clk) begin
    if (bus.errPulse === 1'b1) errSeen <= errSeen + 1;
  end

  typedef struct {
    int entries;
    int exits;
    int tCnt;
    int expP;
    int expW;
    int expEmpty;
    int expFull;
    int expErr;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pulseSensor(input logic doA, input logic doB);
    @(posedge clk); #1;
    bus.a = doA;
    bus.b = doB;
    repeat (8) @(posedge clk);
    #1;
    bus.a = 1'b0;
    bus.b = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.wValid === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({name, " wValid timeout"}, 0, 1);
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int errBefore;
    errBefore = errSeen;
    for (int i = 0; i < v.entries; i++) pulseSensor(1'b1, 1'b0);
    for (int i = 0; i < v.exits; i++)   pulseSensor(1'b0, 1'b1);
    bus.tCount = TC_W'(v.tCnt);
    repeat (2) @(posedge clk);
    #1;
    waitValid($sformatf("vec%0d", idx));
    checkOutput($sformatf("vec%0d pCount", idx), int'(bus.pCount), v.expP);
    checkOutput($sformatf("vec%0d wTime", idx), int'(bus.wTime), v.expW);
    checkOutput($sformatf("vec%0d emptyFlag", idx), int'(bus.emptyFlag), v.expEmpty);
    checkOutput($sformatf("vec%0d fullFlag", idx), int'(bus.fullFlag), v.expFull);
    checkOutput($sformatf("vec%0d errPulse count", idx), errSeen - errBefore, v.expErr);
  endtask

  initial begin
    int cCount;
    int cValid;
    int validAfter;
    int wTimeAfter;
    int errBefore;
    bit seen;

    nCompared = 0;
    nMismatch = 0;
    errSeen   = 0;
    reset     = 1'b1;
    bus.a     = 1'b0;
    bus.b     = 1'b0;
    bus.tCount = TC_W'(1);

    //            entries exits tCnt expP expW empty full err
    vecs[0]  = '{3, 0, 1, 3, 9,  0, 0, 0};
    vecs[1]  = '{0, 0, 3, 3, 5,  0, 0, 0};
    vecs[2]  = '{0, 0, 0, 3, 9,  0, 0, 0};
    vecs[3]  = '{0, 0, 2, 3, 6,  0, 0, 0};
    vecs[4]  = '{3, 0, 3, 6, 8,  0, 0, 0};
    vecs[5]  = '{1, 0, 3, 7, 9,  0, 1, 0};
    vecs[6]  = '{1, 0, 3, 7, 9,  0, 1, 1};
    vecs[7]  = '{0, 0, 1, 7, 21, 0, 1, 0};
    vecs[8]  = '{0, 0, 2, 7, 12, 0, 1, 0};
    vecs[9]  = '{0, 5, 2, 2, 4,  0, 0, 0};
    vecs[10] = '{0, 1, 3, 1, 3,  0, 0, 0};
    vecs[11] = '{0, 1, 3, 0, 0,  1, 0, 0};
    vecs[12] = '{0, 1, 3, 0, 0,  1, 0, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset pCount", int'(bus.pCount), 0);
    checkOutput("reset wTime", int'(bus.wTime), 0);
    checkOutput("reset wValid", int'(bus.wValid), 1);
    checkOutput("reset emptyFlag", int'(bus.emptyFlag), 1);
    checkOutput("reset fullFlag", int'(bus.fullFlag), 0);
    checkOutput("reset errPulse", int'(bus.errPulse), 0);

    // Count and wait-time latency for a single entry with one teller
    cCount = -1;
    cValid = -1;
    validAfter = -1;
    wTimeAfter = -1;
    @(posedge clk); #1;
    bus.a = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (cCount < 0 && bus.pCount == PC_W'(1)) cCount = k;
      else if (cCount > 0 && k == cCount + 1) begin
        validAfter = int'(bus.wValid);
        wTimeAfter = int'(bus.wTime);
      end
      if (cCount > 0 && k > cCount && cValid < 0 && bus.wValid === 1'b1) cValid = k;
    end
    bus.a = 1'b0;
    checkOutput("count latency", cCount, EXP_LAT);
    checkOutput("wValid drop", validAfter, 0);
    checkOutput("wTime held during divide", wTimeAfter, 0);
    checkOutput("wValid latency", cValid - cCount, WT_W + 2);
    checkOutput("wTime p1 t1", int'(bus.wTime), 3);
    repeat (10) @(posedge clk);
    #1;
    pulseSensor(1'b0, 1'b1);
    waitValid("back to empty");
    checkOutput("back to empty pCount", int'(bus.pCount), 0);

    // Table-driven vectors
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Operand change in the middle of a division restarts it
    bus.tCount = TC_W'(1);
    for (int i = 0; i < 3; i++) pulseSensor(1'b1, 1'b0);
    waitValid("abort setup");
    checkOutput("abort setup wTime", int'(bus.wTime), 9);
    @(posedge clk); #1;
    bus.tCount = TC_W'(2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort mid wValid", int'(bus.wValid), 0);
    checkOutput("abort mid wTime held", int'(bus.wTime), 9);
    bus.tCount = TC_W'(3);
    cValid = -1;
    for (int k = 1; k <= 40 && cValid < 0; k++) begin
      @(posedge clk); #1;
      if (bus.wValid === 1'b1) cValid = k;
    end
    checkOutput("abort restart latency", cValid, WT_W + 2);
    checkOutput("abort wTime", int'(bus.wTime), 5);

    // Eight entries from empty, then eight exits
    applyReset();
    errBefore = errSeen;
    for (int i = 0; i < 7; i++) pulseSensor(1'b1, 1'b0);
    checkOutput("fill7 pCount", int'(bus.pCount), 7);
    checkOutput("fill7 errPulse count", errSeen - errBefore, 0);
    pulseSensor(1'b1, 1'b0);
    checkOutput("fill8 pCount", int'(bus.pCount), 7);
    checkOutput("fill8 fullFlag", int'(bus.fullFlag), 1);
    checkOutput("fill8 errPulse count", errSeen - errBefore, 1);
    errBefore = errSeen;
    for (int i = 0; i < 7; i++) pulseSensor(1'b0, 1'b1);
    checkOutput("drain7 pCount", int'(bus.pCount), 0);
    checkOutput("drain7 errPulse count", errSeen - errBefore, 0);
    pulseSensor(1'b0, 1'b1);
    checkOutput("drain8 pCount", int'(bus.pCount), 0);
    checkOutput("drain8 emptyFlag", int'(bus.emptyFlag), 1);
    checkOutput("drain8 errPulse count", errSeen - errBefore, 1);

    // Simultaneous entry and exit at empty and at full
    errBefore = errSeen;
    pulseSensor(1'b1, 1'b1);
    checkOutput("both at empty pCount", int'(bus.pCount), 0);
    checkOutput("both at empty errPulse", errSeen - errBefore, 0);
    for (int i = 0; i < 7; i++) pulseSensor(1'b1, 1'b0);
    errBefore = errSeen;
    pulseSensor(1'b1, 1'b1);
    checkOutput("both at full pCount", int'(bus.pCount), 7);
    checkOutput("both at full errPulse", errSeen - errBefore, 0);

    // Reset while the divider is busy
    bus.tCount = TC_W'(3);
    waitValid("pre-reset");
    @(posedge clk); #1;
    bus.b = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.pCount == PC_W'(6)) seen = 1'b1;
    end
    checkOutput("pre-reset exit seen", int'(seen), 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pre-reset wValid", int'(bus.wValid), 0);
    reset = 1'b1;
    bus.b = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid-div reset pCount", int'(bus.pCount), 0);
    checkOutput("mid-div reset wTime", int'(bus.wTime), 0);
    checkOutput("mid-div reset wValid", int'(bus.wValid), 1);
    checkOutput("mid-div reset emptyFlag", int'(bus.emptyFlag), 1);
    checkOutput("mid-div reset fullFlag", int'(bus.fullFlag), 0);
    reset = 1'b0;

`ifdef SBQM_DEBOUNCE_EN
    // A glitch shorter than the debounce window is ignored
    @(posedge clk); #1;
    bus.a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("glitch pCount", int'(bus.pCount), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
